// File: rtl/mul_unit.sv
// mul_unit: iterative 32x32 radix-2 shift-add multiplier for MUL, UMULL and SMULL.
// A request is accepted only in IDLE. The 32 CALC iterations run on operand
// magnitudes, and SIGN then applies the sign for SMULL. DONE presents the
// registered results with a one-cycle done pulse, 34 cycles after start.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_is_mul
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;

    localparam int PW = 2 * WIDTH;

    // Two's-complement magnitude. The most negative value maps onto itself,
    // which reads back correctly as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] v,
                                               input logic                    take);
        logic [WIDTH-1:0] r;
        r = v;
        if (take && v < 0) begin
            r = -v;
        end
        return r;
    endfunction

    // 64-bit negation that wraps modulo 2^64.
    function automatic logic signed [PW-1:0] f_neg(input logic signed [PW-1:0] v);
        return -v;
    endfunction

    logic [1:0]           r_state;
    logic [5:0]           r_cnt;
    logic [1:0]           r_op;
    logic                 r_neg;
    logic signed [PW-1:0] r_acc;
    logic [PW-1:0]        r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_done;
    logic                 r_is_mul;
    logic [WIDTH-1:0]     r_res_lo;
    logic [WIDTH-1:0]     r_res_hi;

    logic                 w_smull_in;
    logic                 w_long_op;
    logic signed [PW-1:0] w_acc_sum;
    logic signed [PW-1:0] w_acc_final;

    assign w_smull_in  = (i_op == OP_SMULL);
    assign w_long_op   = (r_op == OP_UMULL) || (r_op == OP_SMULL);
    assign w_acc_sum   = r_acc + (r_mplier[0] ? $signed(r_mcand) : $signed({PW{1'b0}}));
    assign w_acc_final = r_neg ? f_neg(r_acc) : r_acc;

    // Sequencer, accumulator and result registers. Reset discards any operation in flight.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_is_mul <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op    <= i_op;
                        r_neg   <= w_smull_in & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    // Results are loaded on the way into DONE so they are valid with done.
                    r_acc    <= w_acc_final;
                    r_res_lo <= w_acc_final[WIDTH-1:0];
                    r_res_hi <= w_long_op ? w_acc_final[PW-1:WIDTH] : '0;
                    r_done   <= 1'b1;
                    r_is_mul <= w_long_op;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_done   <= 1'b0;
                    r_is_mul <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // Shift registers for the operand magnitudes; loaded on accept, shifted each CALC cycle.
    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, f_mag(i_a, w_smull_in)};
            r_mplier <= f_mag(i_b, w_smull_in);
        end else if (r_state == S_CALC) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_is_mul    = r_is_mul;
    assign o_result_lo = r_res_lo;
    assign o_result_hi = r_res_hi;

endmodule
